// File: rtl/led_pwm_ctrl_if.sv
// Data-memory bus seen by led_pwm_ctrl: one store port and one load port, single-cycle, no handshake.
interface led_pwm_ctrl_if;
    logic        mem_wen;
    logic [31:0] mem_wa;
    logic [31:0] mem_wd;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_ra;
    logic [31:0] mem_rd;

    modport master (
        output mem_wen, mem_wa, mem_wd, mem_funct3, mem_ra,
        input  mem_rd
    );

    modport slave (
        input  mem_wen, mem_wa, mem_wd, mem_funct3, mem_ra,
        output mem_rd
    );
endinterface

// File: rtl/led_pwm_ctrl.sv
// Memory-mapped 8-bit PWM for the status LED and RGB LED; duties are double-buffered and
// promoted to the active set at the frame boundary (tick at phase 255).

module led_pwm_ch (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic       i_inv,
    input  logic [7:0] i_phase,
    input  logic [7:0] i_duty,
    output logic       o_pin
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) o_pin <= 1'b0;
        else     o_pin <= (i_en && (i_phase < i_duty)) ^ i_inv;
    end
endmodule

module led_pwm_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_2000
) (
    input  logic          clk,
    input  logic          rst,
    led_pwm_ctrl_if.slave bus,
    output logic          led,
    output logic          red,
    output logic          green,
    output logic          blue
);
    localparam int NUM_CH = 4;  // lanes 0..3 = R, G, B, LED (DUTY byte order)

    typedef struct packed {
        logic              hit;
        logic [1:0]        sel;
        logic [3:0]        be;
        logic [3:0][7:0]   data;
    } wr_req_t;

    wr_req_t                 w_wr;
    logic [1:0]              r_ctrl;
    logic [15:0]             r_prescale;
    logic [NUM_CH-1:0][7:0]  r_duty;
    logic [NUM_CH-1:0][7:0]  r_act;
    logic [15:0]             r_pcnt;
    logic [7:0]              r_phase;
    logic [7:0]              r_frame;
    logic [1:0]              w_ctrl_nxt;
    logic [15:0]             w_pre_nxt;
    logic [NUM_CH-1:0][7:0]  w_duty_nxt;
    logic                    w_tick;
    logic                    w_run;
    logic                    w_rhit;
    logic [31:0]             w_rdat;
    logic [NUM_CH-1:0]       w_inv;
    logic [NUM_CH-1:0]       w_pin;
    logic                    w_unused_ok;

    assign w_unused_ok = &{1'b0, bus.mem_ra[1:0]};

    // Store decode: steer the right-aligned store data onto byte lanes.
    always_comb begin
        w_wr.hit  = bus.mem_wen && (bus.mem_wa[31:4] == BASE_ADDR[31:4]);
        w_wr.sel  = bus.mem_wa[3:2];
        w_wr.be   = 4'b0000;
        w_wr.data = bus.mem_wd;
        case (bus.mem_funct3)
            3'b000: begin
                w_wr.be   = 4'b0001 << bus.mem_wa[1:0];
                w_wr.data = {4{bus.mem_wd[7:0]}};
            end
            3'b001: begin
                w_wr.be   = bus.mem_wa[1] ? 4'b1100 : 4'b0011;
                w_wr.data = {2{bus.mem_wd[15:0]}};
            end
            3'b010:  w_wr.be = 4'b1111;
            default: w_wr.be = 4'b0000;
        endcase
        if (!w_wr.hit) w_wr.be = 4'b0000;
    end

    always_comb begin
        w_ctrl_nxt = r_ctrl;
        w_pre_nxt  = r_prescale;
        w_duty_nxt = r_duty;
        if (w_wr.sel == 2'd0 && w_wr.be[0]) w_ctrl_nxt = w_wr.data[0][1:0];
        if (w_wr.sel == 2'd1) begin
            if (w_wr.be[0]) w_pre_nxt[7:0]  = w_wr.data[0];
            if (w_wr.be[1]) w_pre_nxt[15:8] = w_wr.data[1];
        end
        if (w_wr.sel == 2'd2) begin
            for (int b = 0; b < NUM_CH; b++)
                if (w_wr.be[b]) w_duty_nxt[b] = w_wr.data[b];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl     <= '0;
            r_prescale <= '0;
            r_duty     <= '0;
        end else begin
            r_ctrl     <= w_ctrl_nxt;
            r_prescale <= w_pre_nxt;
            r_duty     <= w_duty_nxt;
        end
    end

    // Counting needs EN both now and after this cycle's store: a clearing store aborts the
    // frame at once, a setting store leaves phase 0 visible for one full cycle.
    assign w_run  = r_ctrl[0] && w_ctrl_nxt[0];
    assign w_tick = (r_pcnt >= r_prescale);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcnt  <= '0;
            r_phase <= '0;
            r_frame <= '0;
            r_act   <= '0;
        end else if (!w_run) begin
            r_pcnt  <= '0;
            r_phase <= '0;
            r_frame <= '0;
            r_act   <= r_duty;
        end else if (w_tick) begin
            r_pcnt  <= '0;
            r_phase <= r_phase + 8'd1;
            if (r_phase == 8'hFF) begin
                r_act   <= r_duty;
                r_frame <= r_frame + 8'd1;
            end
        end else begin
            r_pcnt <= r_pcnt + 16'd1;
        end
    end

    assign w_rhit = (bus.mem_ra[31:4] == BASE_ADDR[31:4]);

    always_comb begin
        w_rdat = '0;
        case (bus.mem_ra[3:2])
            2'd0:    w_rdat = {30'd0, r_ctrl};
            2'd1:    w_rdat = {16'd0, r_prescale};
            2'd2:    w_rdat = r_duty;
            default: w_rdat = {16'd0, r_frame, r_phase};
        endcase
        if (!w_rhit) w_rdat = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) bus.mem_rd <= '0;
        else     bus.mem_rd <= w_rdat;
    end

    assign w_inv = {1'b0, {3{r_ctrl[1]}}};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        led_pwm_ch u_ch (
            .clk     (clk),
            .rst     (rst),
            .i_en    (r_ctrl[0]),
            .i_inv   (w_inv[g]),
            .i_phase (r_phase),
            .i_duty  (r_act[g]),
            .o_pin   (w_pin[g])
        );
    end

    assign red   = w_pin[0];
    assign green = w_pin[1];
    assign blue  = w_pin[2];
    assign led   = w_pin[3];
endmodule

// File: doc/led_pwm_ctrl.md
# led_pwm_ctrl

Memory-mapped PWM controller for the board's status LED and RGB LED. It sits on the core's data-memory bus beside `memory`, decoding a 16-byte register window from the same write and read signals. It drives `LED`, `RGB_R`, `RGB_G` and `RGB_B` with 8-bit PWM. Duty updates are glitch-free because they are double-buffered and applied at the PWM frame boundary.

## Interface
- `BASE_ADDR`, default 32'h0000_2000: base of the register window. Must be 16-byte aligned. The window is `BASE_ADDR`..`BASE_ADDR`+0xF.
- `clk` input 1: system clock. All state is on the rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `mem_wen` input 1: store strobe, one cycle per store.
- `mem_wa` input 32: store byte address.
- `mem_wd` input 32: store data, right-aligned as the core presents it.
- `mem_funct3` input 3: store width. 000 = sb, 001 = sh, 010 = sw. Any other value means no write.
- `mem_ra` input 32: load byte address.
- `mem_rd` output 32: read data, registered. Zero when `mem_ra` is outside the window.
- `led` output 1: PWM for the status LED. Never inverted.
- `red`, `green`, `blue` output 1 each: PWM for the RGB LED. Inverted when `CTRL.INV` is set.

## Operation
- The register is selected by `mem_wa[3:2]` / `mem_ra[3:2]` when `addr[31:4]` equals `BASE_ADDR[31:4]`.
  - 0x0 `CTRL`: bit0 `EN`, bit1 `INV`. Other bits read 0.
  - 0x4 `PRESCALE`: bits [15:0]. Upper bits read 0.
  - 0x8 `DUTY`: shadow duties. [7:0] R, [15:8] G, [23:16] B, [31:24] LED.
  - 0xC `STATUS`: read-only. [7:0] is the current phase; [15:8] is the frame count mod 256. Writes are ignored.
- Write lanes:
  - sb writes byte `mem_wa[1:0]` with `mem_wd[7:0]`.
  - sh writes the halfword at `mem_wa[1]` with `mem_wd[15:0]`; `mem_wa[0]` is ignored.
  - sw writes all 32 bits.
  - Lanes falling on unimplemented bits are dropped.
- Prescaler: 16-bit counter `pcnt`. When `pcnt >= PRESCALE`, a tick fires and `pcnt` returns to 0; otherwise `pcnt` increments. `PRESCALE` = 0 gives a tick every cycle.
- Phase: 8-bit counter that increments on each tick and wraps 255 -> 0.
  - The tick at phase 255 is the frame boundary: the shadow `DUTY` is copied into `active_duty` and `frame` increments.
- Channel output: `ch = EN && (phase < active_duty[ch])`.
  - Duty 0 keeps the channel off. Duty 255 gives 255/256 on-time.
  - `red`, `green` and `blue` are XORed with `INV`; `led` is not.
- When `EN` = 0:
  - `pcnt`, `phase` and `frame` are held at 0.
  - `active_duty` follows the shadow every cycle.
  - Raw channels are 0, so the RGB pins sit at `INV`.
- Clearing `EN` mid-frame aborts the frame; the next cycle is in the disabled state. Setting `EN` starts at phase 0 with `active_duty` equal to the shadow.
- A store to `DUTY` in the same cycle as a frame boundary: `active_duty` takes the pre-store shadow. The new value applies at the next boundary.
- A store to `PRESCALE` takes effect from the next cycle. If `pcnt` already exceeds the new value, the tick fires on that next cycle.

## Timing
- Reset values: all registers 0, `pcnt`/`phase`/`frame` 0, `active_duty` 0, `led`/`red`/`green`/`blue` 0, `mem_rd` 0.
  - Reset takes effect immediately mid-operation; no frame completes.
- Store latency: the register holds the new value at the edge ending the `mem_wen` cycle.
- Load latency: one cycle. `mem_rd` at cycle t+1 reflects `mem_ra` and the register contents at cycle t. There is no bypass of a same-cycle store.
- Output latency: pins are registered. The pin at cycle t+1 reflects `phase`, `active_duty` and `CTRL` at cycle t.
- PWM frame length is 256 × (`PRESCALE`+1) cycles.
- The block never stalls the core. It has no handshake; every access completes in one cycle.

## Test plan
- Reset check: assert `rst` mid-run with `EN` = 1 and duty 0x80 -> all outputs, `mem_rd` and the `STATUS` read are 0 after release.
- Duty cycle: sw `DUTY` = 0x00000080, `PRESCALE` = 0, `CTRL` = 1 -> after the first frame boundary, `red` is high exactly 128 of every 256 cycles; `green`, `blue` and `led` stay 0.
- Store widths: sb 0xFF to `BASE`+0xB, sh 0x1234 to `BASE`+0x8 -> reading `DUTY` returns 0xFF001234. A store with funct3 = 011 leaves it unchanged.
- Shadow timing: change duty 0x40 -> 0xC0 mid-frame, and a second store exactly at the phase-255 tick -> the on-count changes only at the next boundary, and the boundary-cycle store applies one frame later.
- Invert and disable: `CTRL` = 3 with duty 0 -> RGB pins are 1 and `led` is 0. Clear `EN` mid-frame -> next cycle `STATUS` reads phase 0, and RGB stays at 1.
- Read path: load `BASE`+0xC while `PRESCALE` = 3 -> `mem_rd` shows phase advancing once every 4 cycles, one cycle late. A load from `BASE`+0x10 -> `mem_rd` = 0.
